// File: rtl/tdp_bram_pkg.sv
// Shared definitions for the tdp_bram_be true dual-port block RAM:
// read-mode codes, sweep FSM encoding and the byte-lane count helper.
package tdp_bram_pkg;

  localparam int RM_READ_FIRST  = 0;
  localparam int RM_WRITE_FIRST = 1;
  localparam int RM_NO_CHANGE   = 2;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } bram_state_e;

  // Lane count; 0 marks a word width that is not a whole number of lanes.
  function automatic int calc_nb(input int dw, input int bw);
    int nb_v;
    if ((bw > 0) && ((dw % bw) == 0)) begin
      nb_v = dw / bw;
    end else begin
      nb_v = 0;
    end
    return nb_v;
  endfunction

endpackage

// File: rtl/bram_out_stage.sv
// Optional read-data output register with a matching valid flag.
// With out_reg=0 the stage is a pure bypass.
module bram_out_stage #(
  parameter int data_width = 32,
  parameter int out_reg    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_width-1:0] stage_data,
  input  logic                  stage_valid,
  output logic [data_width-1:0] data_r,
  output logic                  valid
);

  if (out_reg != 0) begin : g_reg
    logic [data_width-1:0] data_q_r;
    logic                  valid_q_r;

    // Second pipeline stage: data and valid advance together, flushed by rst.
    always_ff @(posedge clk) begin
      if (rst) begin
        data_q_r  <= '0;
        valid_q_r <= 1'b0;
      end else begin
        data_q_r  <= stage_data;
        valid_q_r <= stage_valid;
      end
    end

    assign data_r = data_q_r;
    assign valid  = valid_q_r;
  end else begin : g_bypass
    logic unused_s;
    assign unused_s = clk ^ rst;
    assign data_r   = stage_data;
    assign valid    = stage_valid;
  end

endmodule

// File: rtl/tdp_bram_be.sv
// True dual-port block RAM with byte-lane writes, selectable read-during-write
// behaviour, cross-port collision detection and a post-reset clear sweep.
module tdp_bram_be
  import tdp_bram_pkg::*;
#(
  parameter int  data_width     = 32,
  parameter int  address_width  = 7,
  parameter int  byte_width     = 8,
  parameter int  read_mode      = 0,
  parameter int  out_reg        = 1,
  parameter int  clear_on_reset = 1,
  localparam int nb             = calc_nb(data_width, byte_width)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_a,
  input  logic [nb-1:0]            we_a,
  input  logic [address_width-1:0] add_a,
  input  logic [data_width-1:0]    data_w_a,
  output logic [data_width-1:0]    data_r_a,
  output logic                     valid_a,
  input  logic                     en_b,
  input  logic [nb-1:0]            we_b,
  input  logic [address_width-1:0] add_b,
  input  logic [data_width-1:0]    data_w_b,
  output logic [data_width-1:0]    data_r_b,
  output logic                     valid_b,
  output logic                     busy,
  output logic                     collision
);

  localparam int depth = 2 ** address_width;

  if (nb == 0) begin : g_bad_width
    $error("tdp_bram_be: data_width must be a multiple of byte_width");
  end

  logic [data_width-1:0]    mem_r [depth];
  bram_state_e              state_r, state_s;
  logic [address_width-1:0] clr_cnt_r;
  logic                     busy_r, collision_r;
  logic                     act_a_s, act_b_s, coll_s;
  logic [data_width:0]      nxt_a_s, nxt_b_s;
  logic [data_width-1:0]    rd1_a_r, rd1_b_r;
  logic                     vld1_a_r, vld1_b_r;

  function automatic logic [data_width-1:0] merge_lanes(
    input logic [data_width-1:0] old_word,
    input logic [data_width-1:0] wr_word,
    input logic [nb-1:0]         we
  );
    logic [data_width-1:0] res;
    res = old_word;
    for (int i = 0; i < nb; i++) begin
      if (we[i]) begin
        res[i*byte_width +: byte_width] = wr_word[i*byte_width +: byte_width];
      end else begin
        res[i*byte_width +: byte_width] = old_word[i*byte_width +: byte_width];
      end
    end
    return res;
  endfunction

  // Returns {valid, data} for one port's access; a colliding access always sees the old word.
  function automatic logic [data_width:0] port_read(
    input logic                  act,
    input logic                  coll,
    input logic [nb-1:0]         we,
    input logic [data_width-1:0] old_word,
    input logic [data_width-1:0] wr_word,
    input logic [data_width-1:0] held
  );
    logic [data_width:0] res;
    res = {1'b0, held};
    if (!act) begin
      res = {1'b0, held};
    end else if (coll || (we == '0)) begin
      res = {1'b1, old_word};
    end else begin
      case (read_mode)
        RM_WRITE_FIRST: res = {1'b1, merge_lanes(old_word, wr_word, we)};
        RM_NO_CHANGE:   res = {1'b0, held};
        default:        res = {1'b1, old_word};
      endcase
    end
    return res;
  endfunction

  // Sweep FSM next state: leave CLEAR once the last word has been zeroed.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: state_s = IDLE;
      CLEAR: begin
        if (clr_cnt_r == {address_width{1'b1}}) begin
          state_s = IDLE;
        end else begin
          state_s = CLEAR;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Sweep FSM state, address counter and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= (clear_on_reset != 0) ? CLEAR : IDLE;
      clr_cnt_r <= '0;
      busy_r    <= (clear_on_reset != 0);
    end else begin
      state_r   <= state_s;
      clr_cnt_r <= (state_r == CLEAR) ? clr_cnt_r + address_width'(1) : '0;
      busy_r    <= (state_s == CLEAR);
    end
  end

  // Port activity and cross-port collision decode.
  always_comb begin
    act_a_s = en_a & ~busy_r & ~rst;
    act_b_s = en_b & ~busy_r & ~rst;
    coll_s  = act_a_s & act_b_s & (add_a == add_b) & ((|we_a) | (|we_b));
    nxt_a_s = port_read(act_a_s, coll_s, we_a, mem_r[add_a], data_w_a, rd1_a_r);
    nxt_b_s = port_read(act_b_s, coll_s, we_b, mem_r[add_b], data_w_b, rd1_b_r);
  end

  // Array writes: the sweep owns the array while busy; port A lanes land last so A wins overlaps.
  always_ff @(posedge clk) begin
    if (busy_r && !rst) begin
      mem_r[clr_cnt_r] <= '0;
    end else begin
      for (int i = 0; i < nb; i++) begin
        if (act_b_s && we_b[i]) begin
          mem_r[add_b][i*byte_width +: byte_width] <= data_w_b[i*byte_width +: byte_width];
        end
        if (act_a_s && we_a[i]) begin
          mem_r[add_a][i*byte_width +: byte_width] <= data_w_a[i*byte_width +: byte_width];
        end
      end
    end
  end

  // First read stage per port plus the collision pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd1_a_r     <= '0;
      vld1_a_r    <= 1'b0;
      rd1_b_r     <= '0;
      vld1_b_r    <= 1'b0;
      collision_r <= 1'b0;
    end else begin
      {vld1_a_r, rd1_a_r} <= nxt_a_s;
      {vld1_b_r, rd1_b_r} <= nxt_b_s;
      collision_r         <= coll_s;
    end
  end

  bram_out_stage #(.data_width(data_width), .out_reg(out_reg)) u_out_a (
    .clk        (clk),
    .rst        (rst),
    .stage_data (rd1_a_r),
    .stage_valid(vld1_a_r),
    .data_r     (data_r_a),
    .valid      (valid_a)
  );

  bram_out_stage #(.data_width(data_width), .out_reg(out_reg)) u_out_b (
    .clk        (clk),
    .rst        (rst),
    .stage_data (rd1_b_r),
    .stage_valid(vld1_b_r),
    .data_r     (data_r_b),
    .valid      (valid_b)
  );

  assign busy      = busy_r;
  assign collision = collision_r;

endmodule

// File: tb/tb_tdp_bram_be.sv
// Self-checking bench: three tdp_bram_be configurations share one stimulus stream
// and are compared every cycle against a word/byte-level reference model.
module tb_tdp_bram_be;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, en_a, en_b;
  logic [3:0]  we_a, we_b, add_a, add_b;
  logic [31:0] data_w_a, data_w_b;
  logic [31:0] dr_a [3];
  logic [31:0] dr_b [3];
  logic        va [3];
  logic        vb [3];
  logic        bsy [3];
  logic        col [3];

  tdp_bram_be #(.data_width(32), .address_width(4), .byte_width(8),
                .read_mode(0), .out_reg(1), .clear_on_reset(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .add_a(add_a), .data_w_a(data_w_a), .data_r_a(dr_a[0]), .valid_a(va[0]),
    .en_b(en_b), .we_b(we_b), .add_b(add_b), .data_w_b(data_w_b), .data_r_b(dr_b[0]), .valid_b(vb[0]),
    .busy(bsy[0]), .collision(col[0]));

  tdp_bram_be #(.data_width(32), .address_width(4), .byte_width(8),
                .read_mode(1), .out_reg(0), .clear_on_reset(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .add_a(add_a), .data_w_a(data_w_a), .data_r_a(dr_a[1]), .valid_a(va[1]),
    .en_b(en_b), .we_b(we_b), .add_b(add_b), .data_w_b(data_w_b), .data_r_b(dr_b[1]), .valid_b(vb[1]),
    .busy(bsy[1]), .collision(col[1]));

  tdp_bram_be #(.data_width(32), .address_width(4), .byte_width(8),
                .read_mode(2), .out_reg(1), .clear_on_reset(1)) u_dut2 (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .add_a(add_a), .data_w_a(data_w_a), .data_r_a(dr_a[2]), .valid_a(va[2]),
    .en_b(en_b), .we_b(we_b), .add_b(add_b), .data_w_b(data_w_b), .data_r_b(dr_b[2]), .valid_b(vb[2]),
    .busy(bsy[2]), .collision(col[2]));

  localparam int rm_c   [3] = '{0, 1, 2};
  localparam int oreg_c [3] = '{1, 0, 1};

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mem_m  [16];
  int          clear_left = 0;
  logic        coll_m = 1'b0;
  logic [31:0] slot_d [3][2];
  logic        slot_v [3][2];
  logic [31:0] out_d  [3][2];
  logic        out_v  [3][2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic port_model(input int k, input int p, input logic act, input logic [3:0] we,
                            input logic coll, input logic [31:0] old_w, input logic [31:0] new_w);
    logic        v;
    logic [31:0] d;
    v = act;
    d = old_w;
    if (act && !coll && (we != 4'h0)) begin
      if (rm_c[k] == 1) d = new_w;
      else if (rm_c[k] == 2) v = 1'b0;
    end
    if (!v) d = slot_d[k][p];
    if (oreg_c[k] == 1) begin
      out_d[k][p] = slot_d[k][p];
      out_v[k][p] = slot_v[k][p];
    end else begin
      out_d[k][p] = d;
      out_v[k][p] = v;
    end
    slot_d[k][p] = d;
    slot_v[k][p] = v;
  endtask

  task automatic model_edge();
    logic        act_a, act_b, coll;
    logic [31:0] old_a, old_b;
    if (rst) begin
      clear_left = 16;
      coll_m     = 1'b0;
      for (int k = 0; k < 3; k++) begin
        for (int p = 0; p < 2; p++) begin
          slot_d[k][p] = 32'h0; slot_v[k][p] = 1'b0;
          out_d[k][p]  = 32'h0; out_v[k][p]  = 1'b0;
        end
      end
      return;
    end
    act_a = en_a && (clear_left == 0);
    act_b = en_b && (clear_left == 0);
    coll  = act_a && act_b && (add_a == add_b) && ((we_a != 4'h0) || (we_b != 4'h0));
    old_a = mem_m[add_a];
    old_b = mem_m[add_b];
    if (clear_left > 0) begin
      mem_m[16 - clear_left] = 32'h0;
      clear_left--;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (act_b && we_b[i]) mem_m[add_b][8*i +: 8] = data_w_b[8*i +: 8];
      end
      for (int i = 0; i < 4; i++) begin
        if (act_a && we_a[i]) mem_m[add_a][8*i +: 8] = data_w_a[8*i +: 8];
      end
    end
    for (int k = 0; k < 3; k++) begin
      port_model(k, 0, act_a, we_a, coll, old_a, mem_m[add_a]);
      port_model(k, 1, act_b, we_b, coll, old_b, mem_m[add_b]);
    end
    coll_m = coll;
  endtask

  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("d%0d_busy", k), 32'(bsy[k]), 32'(clear_left > 0));
      chk($sformatf("d%0d_collision", k), 32'(col[k]), 32'(coll_m));
      chk($sformatf("d%0d_data_r_a", k), dr_a[k], out_d[k][0]);
      chk($sformatf("d%0d_valid_a", k), 32'(va[k]), 32'(out_v[k][0]));
      chk($sformatf("d%0d_data_r_b", k), dr_b[k], out_d[k][1]);
      chk($sformatf("d%0d_valid_b", k), 32'(vb[k]), 32'(out_v[k][1]));
    end
  endtask

  task automatic step(input logic r,
                      input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                      input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
    rst = r;
    en_a = ea; we_a = wa; add_a = aa; data_w_a = da;
    en_b = eb; we_b = wb; add_b = ab; data_w_b = db;
    model_edge();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  function automatic logic any_valid();
    return va[0] | va[1] | va[2] | vb[0] | vb[1] | vb[2];
  endfunction

  initial begin
    int   n;
    logic vseen;
    logic r, ea, eb;
    logic [3:0] wa, wb, aa, ab;
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; we_a = 4'h0; we_b = 4'h0;
    add_a = 4'h0; add_b = 4'h0; data_w_a = 32'h0; data_w_b = 32'h0;
    @(negedge clk);

    // clear sweep after a two-cycle reset; a write during busy is dropped
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    n = 0;
    for (int i = 0; i < 40 && bsy[0]; i++) begin
      n++;
      step(1'b0, (i == 0), (i == 0) ? 4'hF : 4'h0, 4'd3, 32'hDEADBEEF, 1'b0, 4'h0, 4'h0, 32'h0);
    end
    chk("busy_len", n, 32'd16);
    step(1'b0, 1'b1, 4'h0, 4'd3, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    chk("addr3_after_clear", dr_a[0], 32'h0);
    chk("addr3_valid", 32'(va[0]), 32'd1);

    // byte lanes and read latency
    step(1'b0, 1'b1, 4'hF, 4'd5, 32'h11223344, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 4'h5, 4'd5, 32'hAABBCCDD, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b0, 1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    chk("lanes_lat1_data", dr_b[1], 32'h11BB33DD);
    chk("lanes_lat1_valid", 32'(vb[1]), 32'd1);
    chk("lanes_lat2_early_valid", 32'(vb[0]), 32'd0);
    idle();
    chk("lanes_lat2_data", dr_b[0], 32'h11BB33DD);
    chk("lanes_lat2_valid", 32'(vb[0]), 32'd1);

    // same-port read-during-write in all three modes
    step(1'b0, 1'b1, 4'h0, 4'd5, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 4'hF, 4'd7, 32'h00000055, 1'b0, 4'h0, 4'h0, 32'h0);
    chk("wf_data", dr_a[1], 32'h00000055);
    chk("wf_valid", 32'(va[1]), 32'd1);
    idle();
    chk("rf_data", dr_a[0], 32'h0);
    chk("rf_valid", 32'(va[0]), 32'd1);
    chk("nc_data_held", dr_a[2], 32'h11BB33DD);
    chk("nc_valid", 32'(va[2]), 32'd0);

    // cross-port collision
    step(1'b0, 1'b1, 4'h3, 4'd9, 32'hA1A2A3A4, 1'b1, 4'h6, 4'd9, 32'hB1B2B3B4);
    chk("coll_pulse", 32'(col[0]), 32'd1);
    chk("coll_prewrite_wf", dr_a[1], 32'h0);
    idle();
    chk("coll_one_cycle", 32'(col[0]), 32'd0);
    step(1'b0, 1'b1, 4'h0, 4'd9, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    idle();
    chk("coll_merge", dr_a[0], 32'h00B2A3A4);

    // dual read of the same address
    step(1'b0, 1'b1, 4'hF, 4'd2, 32'h12345678, 1'b0, 4'h0, 4'h0, 32'h0);
    step(1'b0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'h0, 4'd2, 32'h0);
    chk("dual_no_coll0", 32'(col[0]), 32'd0);
    idle();
    chk("dual_no_coll1", 32'(col[0]), 32'd0);
    chk("dual_a", dr_a[0], 32'h12345678);
    chk("dual_b", dr_b[0], 32'h12345678);

    // reset with reads in flight, then reset again at sweep count 8
    step(1'b0, 1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    step(1'b1, 1'b1, 4'h0, 4'd2, 32'h0, 1'b1, 4'h0, 4'd5, 32'h0);
    vseen = any_valid();
    for (int i = 0; i < 8; i++) begin
      idle();
      vseen = vseen | any_valid();
    end
    step(1'b1, 1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0, 4'h0, 32'h0);
    vseen = vseen | any_valid();
    n = 0;
    for (int i = 0; i < 40 && bsy[0]; i++) begin
      n++;
      idle();
      vseen = vseen | any_valid();
    end
    chk("midsweep_busy_len", n, 32'd16);
    chk("flushed_no_valid", 32'(vseen), 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 149) == 0);
      ea = ($urandom_range(0, 3) != 0);
      eb = ($urandom_range(0, 3) != 0);
      wa = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      wb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      aa = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      ab = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      step(r, ea, wa, aa, $urandom, eb, wb, ab, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
